// File: rtl/tl_rx_cpl_tag_tracker.sv
// ---------------------------------------------------------------------------
// tl_rx_cpl_tag_tracker
//
// Purpose:
//   Tracks outstanding non-posted request tags issued by TX and matches
//   incoming completion headers against them. A tag is recorded when TX
//   allocates it and is cleared when its final completion arrives.
//   The registered hit/unexpected flags feed the RX uncorrectable-error
//   check stage.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   tx_req_valid/_tag    - TX issues a non-posted request with this tag
//   tx_req_ready         - combinational: the tag is in range and not in use
//   rx_cpl_valid/_tag    - completion header presented for lookup
//   rx_cpl_last          - completion is the final one; retire the tag on a hit
//   rx_cpl_hit           - registered: completion matched an outstanding tag
//   rx_cpl_unexpected    - registered: completion matched no outstanding tag
//   outstanding_cnt      - registered count of valid entries
//   all_idle             - registered: outstanding_cnt == 0
//   timeout_tick         - timebase strobe           (CPL_TIMEOUT_EN only)
//   cpl_timeout          - one-cycle expiry pulse    (CPL_TIMEOUT_EN only)
//   cpl_timeout_tag      - tag that expired          (CPL_TIMEOUT_EN only)
//
// Build option:
//   `define CPL_TIMEOUT_EN adds per-entry timeout counters. Without it the
//   timeout ports do not exist and entries persist until retired by a
//   completion.
// ---------------------------------------------------------------------------
module tl_rx_cpl_tag_tracker #(
    parameter int TAG_WIDTH     = 10,
    parameter int TAG_DEPTH     = 32,
    parameter int CNT_WIDTH     = 6,
    parameter int TIMEOUT_WIDTH = 8,
    parameter int TIMEOUT_LIMIT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_req_valid,
    input  logic [TAG_WIDTH-1:0] tx_req_tag,
    output logic                 tx_req_ready,
    input  logic                 rx_cpl_valid,
    input  logic [TAG_WIDTH-1:0] rx_cpl_tag,
    input  logic                 rx_cpl_last,
    output logic                 rx_cpl_hit,
    output logic                 rx_cpl_unexpected,
    output logic [CNT_WIDTH-1:0] outstanding_cnt,
`ifdef CPL_TIMEOUT_EN
    input  logic                 timeout_tick,
    output logic                 cpl_timeout,
    output logic [TAG_WIDTH-1:0] cpl_timeout_tag,
`endif
    output logic                 all_idle
);

    localparam int IDX_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    // One extra bit so a depth equal to 2**TAG_WIDTH still compares correctly.
    localparam logic [TAG_WIDTH:0] DEPTH_L = (TAG_WIDTH + 1)'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0] valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hit_q, hit_d;
    logic                 unexp_q, unexp_d;
    logic                 idle_q, idle_d;

    logic                 tx_in_range;
    logic                 cpl_in_range;
    logic [IDX_W-1:0]     tx_idx;
    logic [IDX_W-1:0]     cpl_idx;
    logic                 alloc;
    logic                 cpl_match;
    logic                 retire;

    // The index is only meaningful when the tag is in range; the range
    // check gates every use of it.
    assign tx_in_range  = {1'b0, tx_req_tag} < DEPTH_L;
    assign cpl_in_range = {1'b0, rx_cpl_tag} < DEPTH_L;
    assign tx_idx       = tx_req_tag[IDX_W-1:0];
    assign cpl_idx      = rx_cpl_tag[IDX_W-1:0];

    assign tx_req_ready = tx_in_range && !valid_q[tx_idx];
    assign alloc        = tx_req_valid && tx_req_ready;

    // Lookup sees the pre-update valid vector. A same-tag alloc can only
    // proceed when the entry is idle, so alloc and retire never collide.
    assign cpl_match    = rx_cpl_valid && cpl_in_range && valid_q[cpl_idx];
    assign retire       = cpl_match && rx_cpl_last;

`ifdef CPL_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIM = TIMEOUT_WIDTH'(TIMEOUT_LIMIT);

    logic [TIMEOUT_WIDTH-1:0] tmo_q [TAG_DEPTH];
    logic                     tmo_fire;
    logic [IDX_W-1:0]         tmo_idx;
    logic                     tmo_pulse_q;
    logic [TAG_WIDTH-1:0]     tmo_tag_q;

    // Lowest-index expired entry wins; an entry being retired by a final
    // completion this cycle is not reported as timed out.
    always_comb begin
        tmo_fire = 1'b0;
        tmo_idx  = '0;
        for (int i = TAG_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (tmo_q[i] == TMO_LIM) &&
                !(retire && (cpl_idx == IDX_W'(i)))) begin
                tmo_fire = 1'b1;
                tmo_idx  = IDX_W'(i);
            end
        end
    end

    // Counters saturate at the limit so candidates not serviced this cycle
    // stay candidates until their turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tmo_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                if (alloc && (tx_idx == IDX_W'(i))) begin
                    tmo_q[i] <= '0;
                end else if (timeout_tick && valid_q[i] && (tmo_q[i] != TMO_LIM)) begin
                    tmo_q[i] <= tmo_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_pulse_q <= 1'b0;
            tmo_tag_q   <= '0;
        end else begin
            tmo_pulse_q <= tmo_fire;
            tmo_tag_q   <= tmo_fire ? TAG_WIDTH'(tmo_idx) : '0;
        end
    end

    assign cpl_timeout     = tmo_pulse_q;
    assign cpl_timeout_tag = tmo_tag_q;
`endif

    always_comb begin
        valid_d = valid_q;
        if (alloc) begin
            valid_d[tx_idx] = 1'b1;
        end
        if (retire) begin
            valid_d[cpl_idx] = 1'b0;
        end
`ifdef CPL_TIMEOUT_EN
        if (tmo_fire) begin
            valid_d[tmo_idx] = 1'b0;
        end
`endif
    end

    // Bounded by TAG_DEPTH, so the count never wraps.
    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(alloc) - CNT_WIDTH'(retire);
`ifdef CPL_TIMEOUT_EN
        cnt_d = cnt_d - CNT_WIDTH'(tmo_fire);
`endif
    end

    always_comb begin
        hit_d   = cpl_match;
        unexp_d = rx_cpl_valid && !cpl_match;
        idle_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            unexp_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            unexp_q <= unexp_d;
            idle_q  <= idle_d;
        end
    end

    assign rx_cpl_hit        = hit_q;
    assign rx_cpl_unexpected = unexp_q;
    assign outstanding_cnt   = cnt_q;
    assign all_idle          = idle_q;

endmodule

// File: tb/tb_tl_rx_cpl_tag_tracker.sv
// ---------------------------------------------------------------------------
// Directed bench for tl_rx_cpl_tag_tracker. A small reference model tracks
// which tags are outstanding; each presented completion pushes its expected
// {hit, unexpected} pair into a queue that is popped one cycle later when
// the registered flags appear.
// ---------------------------------------------------------------------------
module tb_tl_rx_cpl_tag_tracker;

    logic       clk;
    logic       rst;
    logic       tx_req_valid;
    logic [9:0] tx_req_tag;
    logic       tx_req_ready;
    logic       rx_cpl_valid;
    logic [9:0] rx_cpl_tag;
    logic       rx_cpl_last;
    logic       rx_cpl_hit;
    logic       rx_cpl_unexpected;
    logic [5:0] outstanding_cnt;
    logic       all_idle;
`ifdef CPL_TIMEOUT_EN
    logic       timeout_tick;
    logic       cpl_timeout;
    logic [9:0] cpl_timeout_tag;
`endif

    bit         mdl_valid [32];
    int         mdl_cnt;
    logic [1:0] sb [$];
    int         n_assert;
    int         n_fail;

    tl_rx_cpl_tag_tracker #(
        .TAG_WIDTH    (10),
        .TAG_DEPTH    (32),
        .CNT_WIDTH    (6),
        .TIMEOUT_WIDTH(8),
        .TIMEOUT_LIMIT(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_req_valid     (tx_req_valid),
        .tx_req_tag       (tx_req_tag),
        .tx_req_ready     (tx_req_ready),
        .rx_cpl_valid     (rx_cpl_valid),
        .rx_cpl_tag       (rx_cpl_tag),
        .rx_cpl_last      (rx_cpl_last),
        .rx_cpl_hit       (rx_cpl_hit),
        .rx_cpl_unexpected(rx_cpl_unexpected),
        .outstanding_cnt  (outstanding_cnt),
`ifdef CPL_TIMEOUT_EN
        .timeout_tick     (timeout_tick),
        .cpl_timeout      (cpl_timeout),
        .cpl_timeout_tag  (cpl_timeout_tag),
`endif
        .all_idle         (all_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle with whatever inputs are currently driven.
    task automatic step();
        logic       tx_ok;
        logic       exp_hit;
        logic [1:0] exp_flags;
        #1;
        tx_ok   = (tx_req_tag < 10'd32) && !mdl_valid[tx_req_tag[4:0]];
        exp_hit = rx_cpl_valid && (rx_cpl_tag < 10'd32) && mdl_valid[rx_cpl_tag[4:0]];
        if (tx_req_valid) check("tx_req_ready", 32'(tx_req_ready), 32'(tx_ok));
        if (rx_cpl_valid) sb.push_back({exp_hit, !exp_hit});
        if (exp_hit && rx_cpl_last) begin
            mdl_valid[rx_cpl_tag[4:0]] = 1'b0;
            mdl_cnt--;
        end
        if (tx_req_valid && tx_ok) begin
            mdl_valid[tx_req_tag[4:0]] = 1'b1;
            mdl_cnt++;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_flags = sb.pop_front();
            check("cpl_flags", 32'({rx_cpl_hit, rx_cpl_unexpected}), 32'(exp_flags));
        end else begin
            check("cpl_flags_quiet", 32'({rx_cpl_hit, rx_cpl_unexpected}), 32'd0);
        end
        check("outstanding_cnt", 32'(outstanding_cnt), 32'(mdl_cnt));
        check("all_idle", 32'(all_idle), 32'(mdl_cnt == 0));
    endtask

    task automatic drive(input logic av, input logic [9:0] at,
                         input logic cv, input logic [9:0] ct, input logic cl);
        tx_req_valid = av;
        tx_req_tag   = at;
        rx_cpl_valid = cv;
        rx_cpl_tag   = ct;
        rx_cpl_last  = cl;
        step();
        tx_req_valid = 1'b0;
        rx_cpl_valid = 1'b0;
        rx_cpl_last  = 1'b0;
    endtask

    task automatic alloc(input logic [9:0] t);
        drive(1'b1, t, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic cpl(input logic [9:0] t, input logic last);
        drive(1'b0, 10'd0, 1'b1, t, last);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cnt"}, 32'(outstanding_cnt), 32'd0);
        check({name, "_idle"}, 32'(all_idle), 32'd1);
        check({name, "_hit"}, 32'(rx_cpl_hit), 32'd0);
        check({name, "_unexp"}, 32'(rx_cpl_unexpected), 32'd0);
`ifdef CPL_TIMEOUT_EN
        check({name, "_tmo"}, 32'(cpl_timeout), 32'd0);
        check({name, "_tmo_tag"}, 32'(cpl_timeout_tag), 32'd0);
`endif
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        mdl_cnt      = 0;
        rst          = 1'b1;
        tx_req_valid = 1'b0;
        tx_req_tag   = 10'd0;
        rx_cpl_valid = 1'b0;
        rx_cpl_tag   = 10'd0;
        rx_cpl_last  = 1'b0;
`ifdef CPL_TIMEOUT_EN
        timeout_tick = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request, single final completion.
        alloc(10'd5);
        check("t1_cnt_one", 32'(outstanding_cnt), 32'd1);
        cpl(10'd5, 1'b1);
        check("t1_hit", 32'(rx_cpl_hit), 32'd1);
        check("t1_idle", 32'(all_idle), 32'd1);
        step();

        // Completion with nothing outstanding.
        cpl(10'd7, 1'b1);
        check("t2_unexp", 32'(rx_cpl_unexpected), 32'd1);
        step();
        alloc(10'd7);
        cpl(10'd7, 1'b1);

        // Multi-completion read; re-alloc refused while outstanding.
        alloc(10'd3);
        cpl(10'd3, 1'b0);
        alloc(10'd3);
        check("t3_refused_cnt", 32'(outstanding_cnt), 32'd1);
        cpl(10'd3, 1'b1);
        check("t3_second_hit", 32'(rx_cpl_hit), 32'd1);
        alloc(10'd3);
        cpl(10'd3, 1'b1);

        // Same-cycle alloc and lookup on one tag.
        alloc(10'd9);
        drive(1'b1, 10'd9, 1'b1, 10'd9, 1'b1);
        check("t4_valid_hit", 32'(rx_cpl_hit), 32'd1);
        drive(1'b1, 10'd12, 1'b1, 10'd12, 1'b1);
        check("t4_idle_unexp", 32'(rx_cpl_unexpected), 32'd1);
        alloc(10'd12);
        cpl(10'd12, 1'b1);

        // Back-to-back completions every cycle.
        alloc(10'd10);
        alloc(10'd11);
        cpl(10'd10, 1'b1);
        cpl(10'd11, 1'b0);
        cpl(10'd11, 1'b1);
        cpl(10'd11, 1'b1);
        cpl(10'd40, 1'b0);

        // Fill every entry, then probe a busy tag and an out-of-range tag.
        for (int i = 0; i < 32; i++) alloc(10'(i));
        alloc(10'd31);
        alloc(10'd40);
        check("t5_full_cnt", 32'(outstanding_cnt), 32'd32);
        cpl(10'd4, 1'b0);
        check("t5_pre_reset_hit", 32'(rx_cpl_hit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        for (int i = 0; i < 32; i++) mdl_valid[i] = 1'b0;
        mdl_cnt = 0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        alloc(10'd4);
        cpl(10'd4, 1'b1);

`ifdef CPL_TIMEOUT_EN
        // Two entries expire together; serviced lowest index first.
        alloc(10'd2);
        alloc(10'd6);
        timeout_tick = 1'b1;
        repeat (4) step();
        timeout_tick = 1'b0;
        check("tmo_not_yet", 32'(cpl_timeout), 32'd0);
        mdl_valid[2] = 1'b0;
        mdl_cnt--;
        step();
        check("tmo_first", 32'(cpl_timeout), 32'd1);
        check("tmo_first_tag", 32'(cpl_timeout_tag), 32'd2);
        mdl_valid[6] = 1'b0;
        mdl_cnt--;
        step();
        check("tmo_second", 32'(cpl_timeout), 32'd1);
        check("tmo_second_tag", 32'(cpl_timeout_tag), 32'd6);
        step();
        check("tmo_done", 32'(cpl_timeout), 32'd0);
        cpl(10'd2, 1'b1);
        check("tmo_late_cpl_unexp", 32'(rx_cpl_unexpected), 32'd1);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
